// File: rtl/execute_stage.sv
// Execute stage: ALU, branch resolution and the EX/MEM output register.
// A taken branch redirects fetch for one cycle and discards the next accepted instruction.
module execute_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [4:0]        rd,
  input  logic              reg_write,
  input  logic              is_branch,
  input  logic [DATA_W-1:0] branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  // Operation codes from the ALU controller.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1001;
  localparam logic [3:0] OP_GE  = 4'b1010;
  localparam logic [3:0] OP_LT  = 4'b1100;

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [4:0]        shamt;
    logic [DATA_W-1:0] res;
    shamt = b[4:0];
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SUB:  res = a - b;
      OP_SRA:  res = $unsigned($signed(a) >>> shamt);
      OP_EQ:   res = {{(DATA_W-1){1'b0}}, (a == b)};
      OP_NE:   res = {{(DATA_W-1){1'b0}}, (a != b)};
      OP_GE:   res = {{(DATA_W-1){1'b0}}, ($signed(a) >= $signed(b))};
      OP_LT:   res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res = {DATA_W{1'b0}};
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

  logic              in_ready_s;
  logic              accept_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              branch_taken_s;

  // Handshake and ALU evaluation of the presented instruction.
  always_comb begin
    in_ready_s     = !out_valid_q || out_ready;
    accept_s       = in_valid && in_ready_s;
    alu_result_s   = alu_calc(operation, src_a, src_b);
    branch_taken_s = is_branch && alu_result_s[0];
  end

  // Next-state and output-register logic; a squashed accept behaves like an idle cycle.
  always_comb begin
    state_d          = state_q;
    out_valid_d      = out_valid_q;
    out_result_d     = out_result_q;
    out_rd_d         = out_rd_q;
    out_reg_write_d  = out_reg_write_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (accept_s && (state_q == RUN)) begin
      out_valid_d     = 1'b1;
      out_result_d    = alu_result_s;
      out_rd_d        = rd;
      out_reg_write_d = reg_write;
      if (branch_taken_s) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = branch_target;
        state_d          = SQUASH;
      end else begin
        state_d = RUN;
      end
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (accept_s) begin
        state_d = RUN;
      end else begin
        state_d = state_q;
      end
    end
  end

  // State and EX/MEM register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= RUN;
      out_valid_q      <= 1'b0;
      out_result_q     <= {DATA_W{1'b0}};
      out_rd_q         <= 5'd0;
      out_reg_write_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= {DATA_W{1'b0}};
    end else begin
      state_q          <= state_d;
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_rd_q         <= out_rd_d;
      out_reg_write_q  <= out_reg_write_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_rd         = out_rd_q;
  assign out_reg_write  = out_reg_write_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expected values.
module tb_execute_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd;
  logic        reg_write;
  logic        is_branch;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total;
  int bad;

  execute_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .src_a(src_a), .src_b(src_b), .rd(rd),
    .reg_write(reg_write), .is_branch(is_branch), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic rw, input logic br, input logic [31:0] tgt);
    in_valid      = 1'b1;
    operation     = op;
    src_a         = a;
    src_b         = b;
    rd            = r;
    reg_write     = rw;
    is_branch     = br;
    branch_target = tgt;
  endtask

  task automatic alu_case(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b, 5'd1, 1'b1, 1'b0, 32'h0);
    tick();
    check_val(tag, out_result, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    in_valid = 1'b0; operation = 4'h0; src_a = 32'h0; src_b = 32'h0;
    rd = 5'd0; reg_write = 1'b0; is_branch = 1'b0; branch_target = 32'h0;
    out_ready = 1'b1;
    #12;
    check_val("rst_valid", {31'h0, out_valid}, 32'h0);
    check_val("rst_result", out_result, 32'h0);
    check_val("rst_rd", {27'h0, out_rd}, 32'h0);
    check_val("rst_rw", {31'h0, out_reg_write}, 32'h0);
    check_val("rst_redir", {31'h0, redirect_valid}, 32'h0);
    check_val("rst_pc", redirect_pc, 32'h0);
    check_val("rst_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ADD wrap-around
    drive(4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd5, 1'b1, 1'b0, 32'h0);
    tick();
    check_val("add_valid", {31'h0, out_valid}, 32'h1);
    check_val("add_result", out_result, 32'h0);
    check_val("add_rd", {27'h0, out_rd}, 32'd5);
    check_val("add_rw", {31'h0, out_reg_write}, 32'h1);

    alu_case("sra", 4'b0111, 32'h8000_0000, 32'h24, 32'hF800_0000);
    alu_case("srl", 4'b0101, 32'h8000_0000, 32'h24, 32'h0800_0000);
    alu_case("bad_op", 4'b1111, 32'h1234_5678, 32'h1, 32'h0);
    alu_case("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_case("or", 4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    alu_case("xor", 4'b0011, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
    alu_case("sll", 4'b0100, 32'h0000_0003, 32'h21, 32'h0000_0006);
    alu_case("sub", 4'b0110, 32'h0000_0000, 32'h1, 32'hFFFF_FFFF);
    alu_case("eq", 4'b1000, 32'h55, 32'h55, 32'h1);
    alu_case("ne", 4'b1001, 32'h55, 32'h55, 32'h0);
    alu_case("ge", 4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_case("lt", 4'b1100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1);

    // Taken LT branch, next ADD squashed, following ADD loaded
    drive(4'b1100, 32'hFFFF_FFFE, 32'h1, 5'd0, 1'b0, 1'b1, 32'h100);
    tick();
    check_val("br_redir", {31'h0, redirect_valid}, 32'h1);
    check_val("br_pc", redirect_pc, 32'h100);
    check_val("br_valid", {31'h0, out_valid}, 32'h1);
    check_val("br_result", out_result, 32'h1);
    check_val("br_rw", {31'h0, out_reg_write}, 32'h0);
    drive(4'b0010, 32'd2, 32'd3, 5'd7, 1'b1, 1'b0, 32'h0);
    tick();
    check_val("sq_redir", {31'h0, redirect_valid}, 32'h0);
    check_val("sq_valid", {31'h0, out_valid}, 32'h0);
    check_val("sq_result", out_result, 32'h1);
    drive(4'b0010, 32'd10, 32'd20, 5'd8, 1'b1, 1'b0, 32'h0);
    tick();
    check_val("post_valid", {31'h0, out_valid}, 32'h1);
    check_val("post_result", out_result, 32'd30);
    check_val("post_rd", {27'h0, out_rd}, 32'd8);

    // Backpressure: hold for 3 cycles, then same-cycle accept
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd2, 1'b1, 1'b0, 32'h0);
    #1;
    check_val("bp_ready", {31'h0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("bp_hold_res", out_result, 32'd30);
      check_val("bp_hold_val", {31'h0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    drive(4'b0010, 32'd100, 32'd1, 5'd4, 1'b1, 1'b0, 32'h0);
    #1;
    check_val("bp_release_ready", {31'h0, in_ready}, 32'h1);
    tick();
    check_val("bp_new_res", out_result, 32'd101);
    check_val("bp_new_val", {31'h0, out_valid}, 32'h1);

    // Back-to-back taken branches
    drive(4'b1000, 32'd5, 32'd5, 5'd0, 1'b0, 1'b1, 32'h200);
    tick();
    check_val("b2b_redir1", {31'h0, redirect_valid}, 32'h1);
    check_val("b2b_pc1", redirect_pc, 32'h200);
    drive(4'b1000, 32'd7, 32'd7, 5'd0, 1'b0, 1'b1, 32'h300);
    tick();
    check_val("b2b_redir2", {31'h0, redirect_valid}, 32'h0);
    check_val("b2b_pc2", redirect_pc, 32'h200);
    check_val("b2b_valid2", {31'h0, out_valid}, 32'h0);
    drive(4'b0010, 32'd6, 32'd6, 5'd3, 1'b1, 1'b0, 32'h0);
    tick();
    check_val("b2b_add", out_result, 32'd12);
    check_val("b2b_add_val", {31'h0, out_valid}, 32'h1);

    // Idle drain: valid falls, payload holds
    in_valid = 1'b0;
    tick();
    check_val("idle_valid", {31'h0, out_valid}, 32'h0);
    check_val("idle_result", out_result, 32'd12);

    // Branch under backpressure, then reset while in SQUASH
    out_ready = 1'b0;
    drive(4'b1001, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1, 32'h400);
    tick();
    check_val("bpbr_redir", {31'h0, redirect_valid}, 32'h1);
    check_val("bpbr_pc", redirect_pc, 32'h400);
    in_valid = 1'b0;
    tick();
    check_val("bpbr_pulse", {31'h0, redirect_valid}, 32'h0);
    check_val("bpbr_valid", {31'h0, out_valid}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("mrst_valid", {31'h0, out_valid}, 32'h0);
    check_val("mrst_result", out_result, 32'h0);
    check_val("mrst_pc", redirect_pc, 32'h0);
    check_val("mrst_rd", {27'h0, out_rd}, 32'h0);
    #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(4'b0010, 32'd4, 32'd5, 5'd9, 1'b1, 1'b0, 32'h0);
    tick();
    check_val("after_rst_valid", {31'h0, out_valid}, 32'h1);
    check_val("after_rst_result", out_result, 32'd9);
    check_val("after_rst_rd", {27'h0, out_rd}, 32'd9);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
